// File: rtl/seg_scan_controller_pkg.sv
// Shared constants and types for the seven-segment scan controller.
// Anode patterns, digit index encodings and the captured calculator result.
package seg_scan_controller_pkg;

   localparam int unsigned BCD_W = 4;
   localparam int unsigned OP_W  = 2;

   localparam logic [3:0] AN_IDX0 = 4'b1110;
   localparam logic [3:0] AN_IDX1 = 4'b1101;
   localparam logic [3:0] AN_IDX2 = 4'b1011;
   localparam logic [3:0] AN_IDX3 = 4'b0111;
   localparam logic [3:0] AN_OFF  = 4'b1111;

   typedef enum logic [1:0] {
      IDX_UNITS = 2'd0,
      IDX_TENS  = 2'd1,
      IDX_SIGN  = 2'd2,
      IDX_OP    = 2'd3
   } dig_idx_e;

   typedef struct packed {
      logic             sign;
      logic [BCD_W-1:0] tens;
      logic [BCD_W-1:0] units;
      logic [OP_W-1:0]  op;
   } result_t;

   function automatic logic result_bad(input result_t r);
      return (r.tens > 4'd9) || (r.units > 4'd9);
   endfunction

   function automatic logic [3:0] an_pattern(input dig_idx_e i);
      logic [3:0] p;
      case (i)
         IDX_UNITS: p = AN_IDX0;
         IDX_TENS:  p = AN_IDX1;
         IDX_SIGN:  p = AN_IDX2;
         IDX_OP:    p = AN_IDX3;
      endcase
      return p;
   endfunction

endpackage

// File: rtl/seg_scan_controller_scan_prescaler.sv
// Digit-slot prescaler: counts 0..PRESCALE-1 and pulses tick_o on the last count.
module scan_prescaler #(
   parameter int unsigned PRESCALE = 50000
) (
   input  logic clk,
   input  logic rst_n,
   output logic tick_o
);

   localparam int unsigned   CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam logic [CW-1:0] TC = CW'(PRESCALE - 1);

   logic [CW-1:0] cnt_q, cnt_d;

   assign tick_o = (cnt_q == TC);
   assign cnt_d  = tick_o ? '0 : cnt_q + CW'(1);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) cnt_q <= '0;
      else        cnt_q <= cnt_d;
   end

endmodule

// File: rtl/seg_scan_controller.sv
// Four-digit seven-segment refresh controller with double-buffered result,
// frame-aligned update and blinking-dash error display.
module seg_scan_controller
   import seg_scan_controller_pkg::*;
#(
   parameter int unsigned PRESCALE     = 50000,
   parameter int unsigned BLINK_FRAMES = 64,
   parameter bit          LZ_BLANK     = 1'b1
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       load,
   input  logic       sign_in,
   input  logic [3:0] tens_in,
   input  logic [3:0] units_in,
   input  logic [1:0] op_in,
   output logic [3:0] an_n,
   output logic [3:0] bcd_out,
   output logic       seg_blank,
   output logic       seg_minus,
   output logic       dp_n,
   output logic       upd_done
);

   localparam logic [7:0] BLINK_TC = 8'(BLINK_FRAMES - 1);

   logic       tick, frame_end, xfer;
   dig_idx_e   idx_q, idx_d;
   logic       disp_en_q, disp_en_d;
   logic       pending_q, pending_d;
   result_t    shadow_q, shadow_d;
   result_t    active_q, active_d;
   logic [7:0] blink_cnt_q, blink_cnt_d;
   logic       blink_on_q, blink_on_d;
   logic [3:0] an_q, an_d, bcd_q, bcd_d;
   logic       blank_q, blank_d, minus_q, minus_d, dp_q, dp_d, upd_q, upd_d;

   scan_prescaler #(.PRESCALE(PRESCALE)) u_prescaler (
      .clk    (clk),
      .rst_n  (rst_n),
      .tick_o (tick)
   );

   assign frame_end = tick && (idx_q == IDX_OP);
   // A load on the boundary tick wins: the transfer waits a full frame.
   assign xfer      = frame_end && pending_q && !load;

   always_comb begin : next_state
      idx_d       = tick ? dig_idx_e'(idx_q + 2'd1) : idx_q;
      disp_en_d   = disp_en_q | tick;
      shadow_d    = load ? result_t'{sign_in, tens_in, units_in, op_in} : shadow_q;
      pending_d   = load | (pending_q & ~xfer);
      active_d    = xfer ? shadow_q : active_q;
      blink_cnt_d = blink_cnt_q;
      blink_on_d  = blink_on_q;
      upd_d       = xfer;
      if (xfer) begin
         blink_cnt_d = '0;
         blink_on_d  = 1'b1;
      end else if (frame_end) begin
         if (blink_cnt_q >= BLINK_TC) begin
            blink_cnt_d = '0;
            blink_on_d  = ~blink_on_q;
         end else begin
            blink_cnt_d = blink_cnt_q + 8'd1;
         end
      end
   end

   always_comb begin : out_mux
      an_d    = AN_OFF;
      bcd_d   = '0;
      blank_d = 1'b1;
      minus_d = 1'b0;
      dp_d    = 1'b1;
      if (disp_en_q) begin
         blank_d = 1'b0;
         if (result_bad(active_q)) begin
            minus_d = 1'b1;
            if (blink_on_q) an_d = an_pattern(idx_q);
         end else begin
            an_d = an_pattern(idx_q);
            case (idx_q)
               IDX_UNITS: bcd_d = active_q.units;
               IDX_TENS: begin
                  bcd_d   = active_q.tens;
                  blank_d = LZ_BLANK && (active_q.tens == '0);
               end
               IDX_SIGN: begin
                  minus_d = active_q.sign;
                  blank_d = !active_q.sign;
               end
               IDX_OP: begin
                  bcd_d = {{(BCD_W-OP_W){1'b0}}, active_q.op};
                  dp_d  = 1'b0;
               end
            endcase
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         idx_q       <= IDX_OP;
         disp_en_q   <= 1'b0;
         pending_q   <= 1'b0;
         shadow_q    <= '0;
         active_q    <= '0;
         blink_cnt_q <= '0;
         blink_on_q  <= 1'b1;
         an_q        <= AN_OFF;
         bcd_q       <= '0;
         blank_q     <= 1'b1;
         minus_q     <= 1'b0;
         dp_q        <= 1'b1;
         upd_q       <= 1'b0;
      end else begin
         idx_q       <= idx_d;
         disp_en_q   <= disp_en_d;
         pending_q   <= pending_d;
         shadow_q    <= shadow_d;
         active_q    <= active_d;
         blink_cnt_q <= blink_cnt_d;
         blink_on_q  <= blink_on_d;
         an_q        <= an_d;
         bcd_q       <= bcd_d;
         blank_q     <= blank_d;
         minus_q     <= minus_d;
         dp_q        <= dp_d;
         upd_q       <= upd_d;
      end
   end

   assign an_n      = an_q;
   assign bcd_out   = bcd_q;
   assign seg_blank = blank_q;
   assign seg_minus = minus_q;
   assign dp_n      = dp_q;
   assign upd_done  = upd_q;

endmodule
